pla_vec_driver: RTL and testbench



---
 rtl/pla_vec_driver.sv | 127 ++++++++++++
 tb/tb_pla_vec_driver.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_vec_driver.sv
// Registered vector driver for a 17-input PLA cone: applies a vector, waits SETTLE cycles,
// samples y0 and returns the result with statistics. Define PLA_MISR_EN to add the misr signature.
module pla_vec_driver #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:0]      in_vec,
    output logic [16:0]      x,
    input  logic             y0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      out_vec,
    output logic             out_y,
    input  logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] ones_cnt
`ifdef PLA_MISR_EN
    ,
    output logic [15:0]      misr
`endif
);

    if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
        $error("pla_vec_driver: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       sample;
    logic       done;

    // Both streams: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds with stable data until that transfer.
    assign accept   = (state == ST_IDLE) && in_valid;
    assign sample   = (state == ST_SETTLE) && (cnt == 4'd1);
    assign done     = (state == ST_OUT) && out_ready;
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == 4'd1) state_nxt = ST_OUT;
            ST_OUT:    if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            out_vec   <= '0;
            out_y     <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                x       <= in_vec;
                out_vec <= in_vec;
                cnt     <= 4'(SETTLE);
            end
            if (state == ST_SETTLE) begin
                cnt <= cnt - 4'd1;
            end
            if (sample) begin
                out_y     <= y0;
                out_valid <= 1'b1;
            end
            if (done) begin
                out_valid <= 1'b0;
            end
        end
    end

    // clr has priority over a coincident result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt  <= '0;
            ones_cnt <= '0;
        end else if (clr) begin
            vec_cnt  <= '0;
            ones_cnt <= '0;
        end else if (done) begin
            if (vec_cnt != {CNT_W{1'b1}}) begin
                vec_cnt <= vec_cnt + 1'b1;
            end
            if (out_y && (ones_cnt != {CNT_W{1'b1}})) begin
                ones_cnt <= ones_cnt + 1'b1;
            end
        end
    end

`ifdef PLA_MISR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr <= 16'hFFFF;
        end else if (clr) begin
            misr <= 16'hFFFF;
        end else if (done) begin
            misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h100B : 16'h0000) ^ {15'd0, out_y};
        end
    end
`endif

endmodule

// File: tb/tb_pla_vec_driver.sv
// Bench for pla_vec_driver: four instances (SETTLE 1/3/5/2, the last with 4-bit counters),
// cone stubbed as y0 = x[0], checked against a transaction-level model.
module tb_pla_vec_driver;

    localparam int NI = 4;
    localparam int SET_T [NI] = '{1, 3, 5, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        rst_n_s     [NI];
    logic        in_valid_s  [NI];
    logic        out_ready_s [NI];
    logic        clr_s       [NI];
    logic [16:0] in_vec_s    [NI];
    logic [16:0] x_s         [NI];
    logic [16:0] out_vec_s   [NI];
    logic        in_ready_s  [NI];
    logic        out_valid_s [NI];
    logic        out_y_s     [NI];
    logic        busy_s      [NI];
    logic [15:0] misr_s      [NI];
    logic [15:0] vc_s        [3];
    logic [15:0] oc_s        [3];
    logic [3:0]  vc4;
    logic [3:0]  oc4;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        pla_vec_driver #(.SETTLE(SET_T[g]), .CNT_W(16)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .in_vec    (in_vec_s[g]),
            .x         (x_s[g]),
            .y0        (x_s[g][0]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .out_vec   (out_vec_s[g]),
            .out_y     (out_y_s[g]),
            .clr       (clr_s[g]),
            .busy      (busy_s[g]),
            .vec_cnt   (vc_s[g]),
            .ones_cnt  (oc_s[g])
`ifdef PLA_MISR_EN
            ,
            .misr      (misr_s[g])
`endif
        );
    end

    pla_vec_driver #(.SETTLE(SET_T[3]), .CNT_W(4)) u_dut_sat (
        .clk       (clk),
        .rst_n     (rst_n_s[3]),
        .in_valid  (in_valid_s[3]),
        .in_ready  (in_ready_s[3]),
        .in_vec    (in_vec_s[3]),
        .x         (x_s[3]),
        .y0        (x_s[3][0]),
        .out_valid (out_valid_s[3]),
        .out_ready (out_ready_s[3]),
        .out_vec   (out_vec_s[3]),
        .out_y     (out_y_s[3]),
        .clr       (clr_s[3]),
        .busy      (busy_s[3]),
        .vec_cnt   (vc4),
        .ones_cnt  (oc4)
`ifdef PLA_MISR_EN
        ,
        .misr      (misr_s[3])
`endif
    );

    // Transaction-level reference model
    int          m_vec  [NI];
    int          m_ones [NI];
    logic [15:0] m_misr [NI];
    logic [17:0] exp_q[$];

    function automatic int max_cnt(int k);
        return (k == 3) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] get_vc(int k);
        if (k == 3) return {12'd0, vc4};
        return vc_s[k];
    endfunction

    function automatic logic [15:0] get_oc(int k);
        if (k == 3) return {12'd0, oc4};
        return oc_s[k];
    endfunction

    function automatic logic [15:0] misr_next(logic [15:0] m, logic b);
        logic [16:0] wide;
        wide = {m, 1'b0};
        return wide[15:0] ^ (m[15] ? 16'h100B : 16'h0000) ^ {15'd0, b};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear(int k);
        m_vec[k]  = 0;
        m_ones[k] = 0;
        m_misr[k] = 16'hFFFF;
    endtask

    task automatic model_handshake(int k, logic y, logic c);
        if (c) begin
            model_clear(k);
        end else begin
            if (m_vec[k] < max_cnt(k)) m_vec[k]++;
            if (y && (m_ones[k] < max_cnt(k))) m_ones[k]++;
            m_misr[k] = misr_next(m_misr[k], y);
        end
    endtask

    task automatic check_stats(int k, string tag);
        check({tag, "_vec_cnt"}, 32'(get_vc(k)), 32'(m_vec[k]));
        check({tag, "_ones_cnt"}, 32'(get_oc(k)), 32'(m_ones[k]));
`ifdef PLA_MISR_EN
        check({tag, "_misr"}, 32'(misr_s[k]), 32'(m_misr[k]));
`endif
    endtask

    // One complete transaction: accept, settle, optional stall with junk input, handshake.
    task automatic run_vec(int k, logic [16:0] v, int stall, logic clr_hs, logic clr_mid);
        logic [17:0] exp;
        int lat;
        @(negedge clk);
        check("pre_in_ready", 32'(in_ready_s[k]), 32'd1);
        in_vec_s[k]    = v;
        in_valid_s[k]  = 1'b1;
        out_ready_s[k] = 1'b0;
        exp_q.push_back({v[0], v});
        @(posedge clk);
        #1;
        in_valid_s[k] = 1'b0;
        in_vec_s[k]   = 17'($urandom);
        @(negedge clk);
        check("x_applied", 32'(x_s[k]), 32'(v));
        check("busy_settle", 32'(busy_s[k]), 32'd1);
        check("in_ready_settle", 32'(in_ready_s[k]), 32'd0);
        check("out_valid_early", 32'(out_valid_s[k]), 32'd0);
        lat = 0;
        while (!out_valid_s[k] && lat < 40) begin
            if (clr_mid && lat == 0) begin
                clr_s[k] = 1'b1;
                model_clear(k);
            end
            @(posedge clk);
            lat++;
            #1;
            clr_s[k] = 1'b0;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'(SET_T[k]));
        exp = exp_q.pop_front();
        check("out_vec", 32'(out_vec_s[k]), 32'(exp[16:0]));
        check("out_y", 32'(out_y_s[k]), 32'(exp[17]));
        for (int i = 0; i < stall; i++) begin
            in_valid_s[k] = 1'b1;
            in_vec_s[k]   = 17'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid_s[k]), 32'd1);
            check("stall_out_vec", 32'(out_vec_s[k]), 32'(exp[16:0]));
            check("stall_out_y", 32'(out_y_s[k]), 32'(exp[17]));
            check("stall_in_ready", 32'(in_ready_s[k]), 32'd0);
            check("stall_x", 32'(x_s[k]), 32'(v));
        end
        in_valid_s[k]  = 1'b0;
        out_ready_s[k] = 1'b1;
        clr_s[k]       = clr_hs;
        @(posedge clk);
        #1;
        out_ready_s[k] = 1'b0;
        clr_s[k]       = 1'b0;
        model_handshake(k, exp[17], clr_hs);
        @(negedge clk);
        check("post_out_valid", 32'(out_valid_s[k]), 32'd0);
        check("post_in_ready", 32'(in_ready_s[k]), 32'd1);
        check("post_busy", 32'(busy_s[k]), 32'd0);
        check("post_x_hold", 32'(x_s[k]), 32'(v));
        check_stats(k, "post");
    endtask

    initial begin : main
        logic [16:0] v;
        int acc;
        int seen;
        for (int k = 0; k < NI; k++) begin
            rst_n_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
            clr_s[k] = 1'b0; in_vec_s[k] = '0;
            model_clear(k);
        end

        // Reset state, during and after reset
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_in_ready", 32'(in_ready_s[k]), 32'd1);
            check("rst_busy", 32'(busy_s[k]), 32'd0);
        end
        for (int k = 0; k < NI; k++) rst_n_s[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rel_in_ready", 32'(in_ready_s[k]), 32'd1);
            check("rel_busy", 32'(busy_s[k]), 32'd0);
            check("rel_x", 32'(x_s[k]), 32'd0);
            check("rel_out_valid", 32'(out_valid_s[k]), 32'd0);
            check_stats(k, "rel");
        end

        // SETTLE=1 single vector
        run_vec(0, 17'h10001, 0, 1'b0, 1'b0);
        check("s2_vec_cnt", 32'(get_vc(0)), 32'd1);
        check("s2_ones_cnt", 32'(get_oc(0)), 32'd1);
`ifdef PLA_MISR_EN
        check("s2_misr", 32'(misr_s[0]), 32'h0000EFF4);
`endif

        // SETTLE=3 back-pressure with ignored input pulses
        run_vec(1, 17'h0ACE5, 5, 1'b0, 1'b0);

        // Saturation of 4-bit counters
        for (int i = 0; i < 20; i++) run_vec(3, 17'($urandom) | 17'h1, 0, 1'b0, 1'b0);
        check("sat_vec_cnt", 32'(get_vc(3)), 32'd15);
        check("sat_ones_cnt", 32'(get_oc(3)), 32'd15);
        run_vec(3, 17'h1FFFE, 0, 1'b0, 1'b0);
        check("sat_ones_hold", 32'(get_oc(3)), 32'd15);

        // clr coincident with handshake at vec_cnt=7
        for (int i = 0; i < 6; i++) run_vec(0, 17'($urandom), $urandom_range(0, 2), 1'b0, 1'b0);
        check("s5_pre_vec_cnt", 32'(get_vc(0)), 32'd7);
        run_vec(0, 17'h00003, 0, 1'b1, 1'b0);
        check("s5_vec_cnt", 32'(get_vc(0)), 32'd0);
        check("s5_ones_cnt", 32'(get_oc(0)), 32'd0);
`ifdef PLA_MISR_EN
        check("s5_misr", 32'(misr_s[0]), 32'h0000FFFF);
`endif

        // Reset mid-SETTLE (SETTLE=5)
        run_vec(2, 17'h00001, 0, 1'b0, 1'b0);
        @(negedge clk);
        in_vec_s[2] = 17'h15555; in_valid_s[2] = 1'b1;
        @(posedge clk);
        #1 in_valid_s[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n_s[2] = 1'b0;
        #1;
        check("mid_rst_x", 32'(x_s[2]), 32'd0);
        check("mid_rst_busy", 32'(busy_s[2]), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_s[2]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid_s[2]), 32'd0);
        @(negedge clk);
        rst_n_s[2] = 1'b1;
        model_clear(2);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_s[2]) seen++;
        end
        check("mid_rst_no_out", 32'(seen), 32'd0);
        check_stats(2, "mid_rst");
        run_vec(2, 17'h10001, 0, 1'b0, 1'b0);

        // Sustained throughput on SETTLE=3: one accept per SETTLE+2 cycles
        @(negedge clk);
        in_vec_s[1] = 17'h00001; in_valid_s[1] = 1'b1; out_ready_s[1] = 1'b1;
        acc = 0;
        for (int i = 0; i < 25; i++) begin
            if (in_ready_s[1]) acc++;
            @(negedge clk);
        end
        in_valid_s[1] = 1'b0;
        repeat (10) @(negedge clk);
        out_ready_s[1] = 1'b0;
        check("throughput", 32'(acc), 32'((25 + SET_T[1] + 1) / (SET_T[1] + 2)));
        for (int i = 0; i < acc; i++) model_handshake(1, 1'b1, 1'b0);
        check_stats(1, "thru");

        // Randomized transactions on all instances
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NI; k++) begin
                run_vec(k, 17'($urandom), $urandom_range(0, 3),
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
